// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for fetch/decode/execute/memory/writeback with a shared memory port
module multicycle_sequencer #(
    parameter int WORD        = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WORD-1:0] instr,
    input  logic            memReady,
    output logic            memReq,
    output logic            memWe,
    output logic            addrSel,
    output logic            irWrite,
    output logic            mdrWrite,
    output logic            regWrite,
    output logic            pcWrite,
    output logic            halted,
    output logic            trap,
    output logic [1:0]      trapCause,
    output logic [WORD-1:0] instret
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    cause_next;
    logic [6:0]    opcode;
    logic          is_load, is_store, is_alu, is_ecall, timeout;
    assign opcode   = instr[6:0];
    assign is_load  = opcode == 7'b0000011;
    assign is_store = opcode == 7'b0100011;
    assign is_alu   = ((opcode == 7'b0010011 || opcode == 7'b0110011) && instr[14:12] == 3'b000) || opcode == 7'b0110111;
    assign is_ecall = opcode == 7'b1110011 && instr[31:7] == '0;
    // The final allowed wait cycle still completes if memReady arrives in it
    assign timeout  = wait_cnt == CW'(MEM_TIMEOUT - 1) && !memReady;
    assign halted   = state == HALT;
    assign trap     = state == TRAP;
    // Next-state and datapath strobes; IR/MDR strobes also depend on memReady
    always_comb begin
        state_next = state;
        cause_next = trapCause;
        memReq     = 1'b0;
        memWe      = 1'b0;
        addrSel    = 1'b0;
        irWrite    = 1'b0;
        mdrWrite   = 1'b0;
        regWrite   = 1'b0;
        pcWrite    = 1'b0;
        case (state)
            IDLE:   state_next = start ? FETCH : IDLE;
            FETCH: begin
                memReq     = 1'b1;
                irWrite    = memReady;
                state_next = memReady ? DECODE : timeout ? TRAP : FETCH;
                cause_next = timeout ? 2'd2 : trapCause;
            end
            DECODE: begin
                state_next = (is_load || is_store || is_alu) ? EXEC : is_ecall ? HALT : TRAP;
                cause_next = (is_load || is_store || is_alu || is_ecall) ? trapCause : 2'd1;
            end
            EXEC:   state_next = (is_load || is_store) ? MEM : WB;
            MEM: begin
                memReq     = 1'b1;
                addrSel    = 1'b1;
                memWe      = is_store;
                mdrWrite   = memReady && is_load;
                state_next = memReady ? WB : timeout ? TRAP : MEM;
                cause_next = timeout ? 2'd3 : trapCause;
            end
            WB: begin
                pcWrite    = 1'b1;
                regWrite   = !is_store;
                state_next = FETCH;
            end
            default: state_next = state;
        endcase
    end
    // State, wait counter (cleared on every state change), trap cause and retirement count
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            trapCause <= 2'd0;
            instret   <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= state_next != state ? '0 : wait_cnt + CW'(memReq && !memReady);
            trapCause <= cause_next;
            instret   <= instret + WORD'(state == WB || (state == DECODE && state_next == HALT));
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed scoreboard bench for the multicycle sequencer
module tb_multicycle_sequencer;
    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] LUI   = 32'h123452B7;
    localparam logic [31:0] LW    = 32'h0000A103;
    localparam logic [31:0] SW    = 32'h00112023;
    localparam logic [31:0] BAD   = 32'hFFFFFFFF;
    typedef struct {
        logic [42:0] v;
        string       name;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, memReady = 1'b0, probe = 1'b0, done = 1'b0;
    logic [31:0] instr = '0;
    logic        memReq, memWe, addrSel, irWrite, mdrWrite, regWrite, pcWrite, halted, trap;
    logic [1:0]  trapCause;
    logic [31:0] instret;
    exp_t        sb[$];
    int          tests = 0, fails = 0;
    multicycle_sequencer #(.WORD(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .memReady(memReady),
        .memReq(memReq), .memWe(memWe), .addrSel(addrSel), .irWrite(irWrite),
        .mdrWrite(mdrWrite), .regWrite(regWrite), .pcWrite(pcWrite), .halted(halted),
        .trap(trap), .trapCause(trapCause), .instret(instret)
    );
    always #5 clk = ~clk;
    // Push one expected output snapshot: {memReq,memWe,addrSel,irWrite,mdrWrite,regWrite,pcWrite,halted,trap,trapCause,instret}
    task automatic e(input string n, input logic mr, we, as, ir, mdr, rw, pw, h, t, input logic [1:0] c, input logic [31:0] cnt);
        exp_t x;
        x.v    = {mr, we, as, ir, mdr, rw, pw, h, t, c, cnt};
        x.name = n;
        sb.push_back(x);
    endtask
    // Drive one cycle of inputs; the monitor samples at the following negedge
    task automatic cyc(input logic s, input logic [31:0] i, input logic r, input logic p);
        start = s; instr = i; memReady = r; probe = p;
        @(posedge clk);
        #1;
    endtask
    task automatic do_rst();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
    endtask
    // Monitor: compares on any strobe or explicit probe
    initial begin
        logic [42:0] act;
        exp_t        x;
        forever begin
            @(negedge clk);
            act = {memReq, memWe, addrSel, irWrite, mdrWrite, regWrite, pcWrite, halted, trap, trapCause, instret};
            if (done) begin
                tests++;
                if (sb.size() != 0) begin
                    fails++;
                    $display("FAIL leftover: %0d expected events never seen, required 0", sb.size());
                end
            end else if (irWrite || mdrWrite || regWrite || pcWrite || probe) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %h, no expectation queued", act);
                end else begin
                    x = sb.pop_front();
                    if (act !== x.v) begin
                        fails++;
                        $display("FAIL %s: got %h required %h", x.name, act, x.v);
                    end
                end
            end
        end
    end
    initial begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        e("reset", 0,0,0,0,0,0,0,0,0,2'd0,0);              cyc(0, 0, 1, 1);
        // ADDI then ECALL, memory always ready
        cyc(1, ADDI, 1, 0);
        e("t1_fetch", 1,0,0,1,0,0,0,0,0,2'd0,0);           cyc(1, ADDI, 1, 0);
        cyc(1, ADDI, 1, 0);
        cyc(1, ADDI, 1, 0);
        e("t1_wb", 0,0,0,0,0,1,1,0,0,2'd0,0);              cyc(1, ADDI, 1, 0);
        e("t1_fetch2", 1,0,0,1,0,0,0,0,0,2'd0,1);          cyc(1, ADDI, 1, 0);
        cyc(1, ECALL, 1, 0);
        e("t1_halt", 0,0,0,0,0,0,0,1,0,2'd0,2);            cyc(1, ECALL, 1, 1);
        e("t1_halt_hold", 0,0,0,0,0,0,0,1,0,2'd0,2);       cyc(1, ECALL, 1, 1);
        do_rst();
        // LUI, then LW with memReady only on the third MEM cycle
        cyc(1, LUI, 1, 0);
        e("t2_lui_fetch", 1,0,0,1,0,0,0,0,0,2'd0,0);       cyc(1, LUI, 1, 0);
        cyc(1, LUI, 1, 0);
        cyc(1, LUI, 1, 0);
        e("t2_lui_wb", 0,0,0,0,0,1,1,0,0,2'd0,0);          cyc(1, LUI, 1, 0);
        e("t2_lw_fetch", 1,0,0,1,0,0,0,0,0,2'd0,1);        cyc(0, LW, 1, 0);
        cyc(0, LW, 1, 0);
        cyc(0, LW, 1, 0);
        e("t2_mem_wait1", 1,0,1,0,0,0,0,0,0,2'd0,1);       cyc(0, LW, 0, 1);
        e("t2_mem_wait2", 1,0,1,0,0,0,0,0,0,2'd0,1);       cyc(0, LW, 0, 1);
        e("t2_mem_done", 1,0,1,0,1,0,0,0,0,2'd0,1);        cyc(0, LW, 1, 0);
        e("t2_wb", 0,0,0,0,0,1,1,0,0,2'd0,1);              cyc(0, LW, 0, 0);
        // SW, memory always ready
        e("t3_fetch", 1,0,0,1,0,0,0,0,0,2'd0,2);           cyc(0, SW, 1, 0);
        cyc(0, SW, 1, 0);
        cyc(0, SW, 1, 0);
        e("t3_mem", 1,1,1,0,0,0,0,0,0,2'd0,2);             cyc(0, SW, 1, 1);
        e("t3_wb", 0,0,0,0,0,0,1,0,0,2'd0,2);              cyc(0, SW, 1, 0);
        // Illegal instruction
        e("t4_fetch", 1,0,0,1,0,0,0,0,0,2'd0,3);           cyc(0, BAD, 1, 0);
        cyc(0, BAD, 1, 0);
        e("t4_trap", 0,0,0,0,0,0,0,0,1,2'd1,3);            cyc(1, BAD, 1, 1);
        e("t4_trap_hold", 0,0,0,0,0,0,0,0,1,2'd1,3);       cyc(1, BAD, 1, 1);
        do_rst();
        // Fetch timeout after four wait cycles
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            e("t5_fetch_wait", 1,0,0,0,0,0,0,0,0,2'd0,0);  cyc(0, 0, 0, 1);
        end
        e("t5_fetch_trap", 0,0,0,0,0,0,0,0,1,2'd2,0);      cyc(0, 0, 1, 1);
        do_rst();
        // Ready in the last allowed fetch cycle completes; then data timeout
        cyc(1, LW, 0, 0);
        for (int k = 0; k < 3; k++) begin
            e("t5_fetch_wait_b", 1,0,0,0,0,0,0,0,0,2'd0,0); cyc(0, LW, 0, 1);
        end
        e("t5_fetch_last", 1,0,0,1,0,0,0,0,0,2'd0,0);      cyc(0, LW, 1, 0);
        cyc(0, LW, 0, 0);
        cyc(0, LW, 0, 0);
        for (int k = 0; k < 4; k++) begin
            e("t5_mem_wait", 1,0,1,0,0,0,0,0,0,2'd0,0);    cyc(0, LW, 0, 1);
        end
        e("t5_mem_trap", 0,0,0,0,0,0,0,0,1,2'd3,0);        cyc(0, LW, 1, 1);
        do_rst();
        // Reset in the middle of a MEM handshake
        cyc(1, LUI, 1, 0);
        e("t6_lui_fetch", 1,0,0,1,0,0,0,0,0,2'd0,0);       cyc(1, LUI, 1, 0);
        cyc(1, LUI, 1, 0);
        cyc(1, LUI, 1, 0);
        e("t6_lui_wb", 0,0,0,0,0,1,1,0,0,2'd0,0);          cyc(1, LUI, 1, 0);
        e("t6_lw_fetch", 1,0,0,1,0,0,0,0,0,2'd0,1);        cyc(0, LW, 1, 0);
        cyc(0, LW, 1, 0);
        cyc(0, LW, 1, 0);
        e("t6_mem_wait", 1,0,1,0,0,0,0,0,0,2'd0,1);        cyc(0, LW, 0, 1);
        rst = 1'b1;
        e("t6_mem_in_rst", 1,0,1,0,0,0,0,0,0,2'd0,1);      cyc(0, LW, 0, 1);
        rst = 1'b0;
        e("t6_after_rst", 0,0,0,0,0,0,0,0,0,2'd0,0);       cyc(0, LW, 1, 1);
        probe = 1'b0;
        done  = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
